cpu_step_ctrl: RTL

Run/step sequencer for the board-level MIPS core. It turns board switches and a raw push-button into a single-cycle clock-enable pulse (`cpu_tick`) on the 100 MHz board clock, so the core advances one cycle per pulse. Supported modes are free-running (slow or quick rate), single-step and PC-low-byte breakpoint. It sits between the board I/O and `top`, replacing the `clkrun & clken` gating.

---
 rtl/cpu_step_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_step_ctrl
//
// Run/step sequencer for the board-level MIPS core. It turns the run/quick
// switches and a raw step push-button into a single-cycle clock-enable pulse
// (cpu_tick) on the 100 MHz board clock. The core advances exactly one cycle
// per pulse. Supported modes:
//   - free-running at a slow or quick rate
//   - single-step on a debounced button press
//   - breakpoint on the low byte of the PC
//
// cpu_tick is a plain one-cycle enable with no return path. The core must
// consume it on the edge that follows the cycle in which it is high. There is
// no backpressure.
//
// Parameters:
//   DEB_CYCLES  consecutive stable cycles needed to accept a button level
//   SLOW_DIV    tick period in cycles when quick=0 (>= 4)
//   FAST_DIV    tick period in cycles when quick=1 (>= 4)
//
// Ports:
//   CLK100MHZ  in   1  board clock, the only clock in the block
//   reset      in   1  synchronous, active-low
//   run        in   1  run switch (level)
//   quick      in   1  selects FAST_DIV over SLOW_DIV, sampled at load time
//   step_btn   in   1  raw asynchronous step button
//   bp_en      in   1  breakpoint enable
//   bp_addr    in   8  breakpoint PC low byte
//   pclow      in   8  core PC[7:0]
//   memwrite   in   2  core memory-write strobe
//   cpu_tick   out  1  core clock-enable, one cycle per advance
//   state      out  2  FSM state: IDLE=0, RUN=1, STEP_REL=2, BREAK=3
//   tick_cnt   out  8  count of issued ticks, wraps 255->0
//
// Build option:
//   CPU_WR_HOLD_EN  When defined, a RUN tick followed by memwrite != 0 in
//                   the next cycle stretches the period started by that tick
//                   to 2x. This holds the store on the display for longer.
//                   When undefined, memwrite is ignored.
// ---------------------------------------------------------------------------
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int SLOW_DIV   = 250_000_000,
    parameter int FAST_DIV   = 62_500_000
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       run,
    input  logic       quick,
    input  logic       step_btn,
    input  logic       bp_en,
    input  logic [7:0] bp_addr,
    input  logic [7:0] pclow,
    input  logic [1:0] memwrite,
    output logic       cpu_tick,
    output logic [1:0] state,
    output logic [7:0] tick_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STEP_REL = 2'd2,
        S_BREAK    = 2'd3
    } state_t;

    localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);
    localparam logic [31:0] SLOW_LD  = 32'(SLOW_DIV - 1);
    localparam logic [31:0] FAST_LD  = 32'(FAST_DIV - 1);

    // -----------------------------------------------------------------------
    // Button path: 2-FF synchronizer, debounce counter, rising-edge detect
    // -----------------------------------------------------------------------
    logic        sync1;
    logic        sync2;
    logic        btn_db;
    logic        btn_db_q;
    logic [31:0] deb_cnt;
    logic        press;

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= step_btn;
            sync2    <= sync1;
            btn_db_q <= btn_db;
            // The count only runs while the synchronized level disagrees
            // with the accepted level. Any agreement (a bounce) restarts it.
            if (sync2 == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    // -----------------------------------------------------------------------
    // FSM, divider and tick generation
    // -----------------------------------------------------------------------
    state_t      st;
    state_t      st_n;
    logic        tick_n;
    logic        run_tick_n;
    logic [31:0] div_cnt;
    logic [31:0] div_n;
    // rtick_q1 is high alongside cpu_tick for RUN ticks. rtick_q2 is high one
    // cycle later, once the core has advanced and pclow/memwrite reflect the
    // ticked instruction.
    logic        rtick_q1;
    logic        rtick_q2;
    logic        bp_hit;

`ifdef CPU_WR_HOLD_EN
    // Period loaded at the last divider load, used to stretch it once.
    logic [31:0] cur_per;
    logic [31:0] per_n;
`else
    logic        unused_memwrite;
    assign unused_memwrite = ^memwrite;
`endif

    assign bp_hit = rtick_q2 && bp_en && (pclow == bp_addr);

    always_comb begin
        st_n       = st;
        tick_n     = 1'b0;
        run_tick_n = 1'b0;
        div_n      = div_cnt;
`ifdef CPU_WR_HOLD_EN
        per_n      = cur_per;
`endif
        case (st)
            S_IDLE: begin
                // A press wins over the run switch.
                if (press) begin
                    tick_n = 1'b1;
                    st_n   = S_STEP_REL;
                end else if (run) begin
                    st_n  = S_RUN;
                    div_n = quick ? FAST_LD : SLOW_LD;
`ifdef CPU_WR_HOLD_EN
                    per_n = quick ? 32'(FAST_DIV) : 32'(SLOW_DIV);
`endif
                end
            end
            S_RUN: begin
                // Leaving RUN suppresses a tick even at terminal count.
                if (!run) begin
                    st_n = S_IDLE;
                end else if (bp_hit) begin
                    st_n = S_BREAK;
                end else if (div_cnt == '0) begin
                    tick_n     = 1'b1;
                    run_tick_n = 1'b1;
                    div_n      = quick ? FAST_LD : SLOW_LD;
`ifdef CPU_WR_HOLD_EN
                    per_n      = quick ? 32'(FAST_DIV) : 32'(SLOW_DIV);
`endif
                end else begin
                    div_n = div_cnt - 32'd1;
`ifdef CPU_WR_HOLD_EN
                    // A store follows the tick, so add one more period to
                    // the count in progress. Only this period is stretched.
                    if (rtick_q2 && (memwrite != 2'b00)) begin
                        div_n = div_cnt - 32'd1 + cur_per;
                    end
`endif
                end
            end
            S_STEP_REL: begin
                if (!btn_db) begin
                    st_n = S_IDLE;
                end
            end
            S_BREAK: begin
                // Step/continue. If run is still set, IDLE resumes RUN
                // after the button is released.
                if (press) begin
                    tick_n = 1'b1;
                    st_n   = S_STEP_REL;
                end else if (!run) begin
                    st_n = S_IDLE;
                end
            end
            default: begin
                st_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            st       <= S_IDLE;
            cpu_tick <= 1'b0;
            tick_cnt <= 8'd0;
            div_cnt  <= '0;
            rtick_q1 <= 1'b0;
            rtick_q2 <= 1'b0;
`ifdef CPU_WR_HOLD_EN
            cur_per  <= '0;
`endif
        end else begin
            st       <= st_n;
            cpu_tick <= tick_n;
            tick_cnt <= tick_cnt + {7'd0, tick_n};
            div_cnt  <= div_n;
            rtick_q1 <= run_tick_n;
            rtick_q2 <= rtick_q1;
`ifdef CPU_WR_HOLD_EN
            cur_per  <= per_n;
`endif
        end
    end

    assign state = st;

endmodule
